// File: rtl/ula_bist.sv
// rtl/ula_bist.sv - built-in self-test engine for the 32-bit ULA
`timescale 1ns/1ps
module ula_bist #(
  parameter int unsigned NUM_VEC = 64,
  parameter logic [31:0] SEED    = 32'd1234,
  parameter bit          CHECK_V = 1'b1,
  parameter int unsigned ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      ula_A,
  output logic [31:0]      ula_B,
  output logic [2:0]       ula_func,
  input  logic [31:0]      ula_R,
  input  logic             ula_pinV,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail_idx,
  output logic [2:0]       first_fail_func
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t      state;
  logic [15:0] idx;
  logic [31:0] lfsr;

  logic [31:0]      sum, diff, exp_r;
  logic             exp_v, mismatch;
  logic [ERR_W-1:0] err_next;
  logic [15:0]      nidx;
  logic [31:0]      nxt_a, nxt_b, lfsr_next;
  logic [2:0]       nxt_f;
  logic             load_rand;

  // Golden model evaluated on the registered operands the ULA is currently seeing
  always_comb begin
    sum   = ula_A + ula_B;
    diff  = ula_A - ula_B;
    exp_v = 1'b0;
    case (ula_func)
      3'b000: begin
        exp_r = sum;
        exp_v = (ula_A[31] == ula_B[31]) && (sum[31] != ula_A[31]);
      end
      3'b001: begin
        exp_r = diff;
        exp_v = (ula_A[31] != ula_B[31]) && (diff[31] != ula_A[31]);
      end
      3'b010:  exp_r = ula_A & ula_B;
      3'b011:  exp_r = ula_A | ula_B;
      3'b100:  exp_r = ~(ula_A ^ ula_B);
      3'b101:  exp_r = ~ula_A;
      3'b110:  exp_r = ula_A;
      default: exp_r = ~ula_B;
    endcase
    mismatch = (ula_R != exp_r) ||
               (CHECK_V && (ula_func[2:1] == 2'b00) && (ula_pinV != exp_v));
    err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
  end

  // Next vector: three more directed ones, then LFSR-derived operands
  always_comb begin
    nidx      = idx + 16'd1;
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
    load_rand = (nidx >= 16'd4);
    case (nidx)
      16'd1: begin nxt_a = 32'hFFFFFFFF; nxt_b = 32'hFFFFFFFF; nxt_f = 3'b000; end
      16'd2: begin nxt_a = 32'h0;        nxt_b = 32'h0;        nxt_f = 3'b001; end
      16'd3: begin nxt_a = 32'hFFFFFFFF; nxt_b = 32'hFFFFFFFF; nxt_f = 3'b001; end
      default: begin
        nxt_a = lfsr;
        nxt_b = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A5A5A;
        nxt_f = nidx[2:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      lfsr            <= '0;
      ula_A           <= '0;
      ula_B           <= '0;
      ula_func        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_func <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= APPLY;
            idx             <= '0;
            lfsr            <= SEED_EFF;
            ula_A           <= '0;
            ula_B           <= '0;
            ula_func        <= 3'b000;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_func <= '0;
          end
        end
        APPLY: state <= CHECK;
        CHECK: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            first_fail_idx  <= idx;
            first_fail_func <= ula_func;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state    <= APPLY;
            idx      <= nidx;
            ula_A    <= nxt_a;
            ula_B    <= nxt_b;
            ula_func <= nxt_f;
            if (load_rand) lfsr <= lfsr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_bist.sv
// tb/tb_ula_bist.sv - scoreboard bench for ula_bist with a faultable ULA model
`timescale 1ns/1ps
module tb_ula_bist;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;  // 0 good, 1 R[0] stuck-at-1, 2 pinV stuck-at-1, 3 outputs forced 0

  logic [31:0] a1, b1, r1, a2, b2, r2;
  logic [2:0]  f1, f2, fff1, fff2;
  logic        v1, v2, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err1, ffi1, ffi2;
  logic [3:0]  err2;

  int checks = 0;
  int errors = 0;

  typedef struct {int err; bit pass; int ffi; int fff;} res_t;
  res_t        res_q1[$];
  res_t        res_q2[$];
  logic [66:0] vec_q[$];

  ula_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ula_A(a1), .ula_B(b1), .ula_func(f1), .ula_R(r1), .ula_pinV(v1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_idx(ffi1), .first_fail_func(fff1)
  );

  ula_bist #(.NUM_VEC(N), .SEED(32'd0), .CHECK_V(1'b0), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ula_A(a2), .ula_B(b2), .ula_func(f2), .ula_R(r2), .ula_pinV(v2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_idx(ffi2), .first_fail_func(fff2)
  );

  function automatic logic [32:0] golden(logic [31:0] a, logic [31:0] b, logic [2:0] f);
    longint s;
    longint lim = 64'sh7FFFFFFF;
    logic [31:0] r;
    logic v = 1'b0;
    case (f)
      3'd0: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; v = (s > lim) || (s < -lim - 1); end
      3'd1: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; v = (s > lim) || (s < -lim - 1); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~(a ^ b);
      3'd5: r = ~a;
      3'd6: r = a;
      default: r = ~b;
    endcase
    return {v, r};
  endfunction

  function automatic logic [32:0] ula_model(logic [31:0] a, logic [31:0] b, logic [2:0] f, int m);
    logic [32:0] x = golden(a, b, f);
    if (m == 1) x[0] = 1'b1;
    if (m == 2) x[32] = 1'b1;
    if (m == 3) x = '0;
    return x;
  endfunction

  always_comb begin
    {v1, r1} = ula_model(a1, b1, f1, mode);
    {v2, r2} = ula_model(a2, b2, f2, mode);
  end

  function automatic logic [66:0] vec_at(int i, inout logic [31:0] l);
    logic [31:0] a, b;
    logic [2:0] f;
    case (i)
      0: begin a = 32'h0;        b = 32'h0;        f = 3'd0; end
      1: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; f = 3'd0; end
      2: begin a = 32'h0;        b = 32'h0;        f = 3'd1; end
      3: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; f = 3'd1; end
      default: begin
        a = l;
        b = {a[15:0], a[31:16]} ^ 32'h5A5A5A5A;
        f = 3'(i % 8);
        l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
      end
    endcase
    return {a, b, f};
  endfunction

  function automatic res_t model_run(int m, bit checkv, int errw, logic [31:0] seed);
    res_t res;
    logic [31:0] l = (seed == 0) ? 32'd1 : seed;
    logic [66:0] v;
    logic [32:0] g, u;
    int cnt = 0;
    res.ffi = 0;
    res.fff = 0;
    for (int i = 0; i < N; i++) begin
      v = vec_at(i, l);
      g = golden(v[66:35], v[34:3], v[2:0]);
      u = ula_model(v[66:35], v[34:3], v[2:0], m);
      if ((u[31:0] != g[31:0]) || (checkv && v[2:0] < 3'd2 && u[32] != g[32])) begin
        if (cnt == 0) begin res.ffi = i; res.fff = int'(v[2:0]); end
        cnt++;
      end
    end
    res.err  = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
    res.pass = (cnt == 0);
    return res;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic predict();
    logic [31:0] l = 32'd1234;
    res_q1.push_back(model_run(mode, 1'b1, 16, 32'd1234));
    res_q2.push_back(model_run(mode, 1'b0, 4, 32'd0));
    for (int i = 0; i < N; i++) vec_q.push_back(vec_at(i, l));
  endtask

  task automatic pulse_start();
    predict();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done1 && done2) && n < 4 * N + 20) begin
      @(negedge clk);
      n++;
    end
    if (!(done1 && done2)) check("done_timeout", 64'(n), 64'(2 * N));
  endtask

  int   bc1 = 0, bc2 = 0;
  logic done1_q = 1'b0, done2_q = 1'b0;

  always @(negedge clk) begin : mon1
    res_t r;
    logic [66:0] ev;
    if (busy1) begin
      bc1++;
      if (bc1 % 2 == 1) begin
        if (vec_q.size() == 0) check("vec_underflow", 64'd1, 64'd0);
        else begin
          ev = vec_q.pop_front();
          check("vector", 64'({a1, b1, f1} ^ ev), 64'd0);
        end
      end
    end else begin
      if (done1 && !done1_q) begin
        check("latency1", 64'(bc1), 64'(2 * N));
        if (res_q1.size() == 0) check("res1_underflow", 64'd1, 64'd0);
        else begin
          r = res_q1.pop_front();
          check("err1", 64'(err1), 64'(r.err));
          check("pass1", 64'(pass1), 64'(r.pass));
          check("ffi1", 64'(ffi1), 64'(r.ffi));
          check("fff1", 64'(fff1), 64'(r.fff));
        end
      end
      bc1 = 0;
    end
    done1_q = done1;
  end

  always @(negedge clk) begin : mon2
    res_t r;
    if (busy2) bc2++;
    else begin
      if (done2 && !done2_q) begin
        check("latency2", 64'(bc2), 64'(2 * N));
        if (res_q2.size() == 0) check("res2_underflow", 64'd1, 64'd0);
        else begin
          r = res_q2.pop_front();
          check("err2", 64'(err2), 64'(r.err));
          check("pass2", 64'(pass2), 64'(r.pass));
          check("ffi2", 64'(ffi2), 64'(r.ffi));
          check("fff2", 64'(fff2), 64'(r.fff));
        end
      end
      bc2 = 0;
    end
    done2_q = done2;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_status", 64'({busy1, done1, pass1, err1, ffi1, fff1}), 64'd0);
    check("reset_ula", 64'({a1, b1, f1} != 67'd0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0;
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    predict();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 64'(done1), 64'd0);
    check("restart_busy", 64'(busy1), 64'd1);
    check("restart_err", 64'({err1, ffi1, fff1}), 64'd0);
    wait_done();

    for (int m = 1; m <= 3; m++) begin
      mode = m;
      @(negedge clk);
      pulse_start();
      wait_done();
    end

    mode = 0;
    @(negedge clk);
    pulse_start();
    repeat (48) @(negedge clk);
    #2;
    vec_q.delete();
    res_q1.delete();
    res_q2.delete();
    rst_n = 1'b0;
    #1;
    check("midreset_status", 64'({busy1, done1, err1, busy2, done2, err2}), 64'd0);
    check("midreset_ula", 64'({a1, b1, f1} != 67'd0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({busy1, done1, busy2, done2}), 64'd0);
    mode = 1;
    pulse_start();
    wait_done();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
